// File: rtl/matrix_store_manager_if.sv
// matrix_store_manager_if: allocation, lookup and BRAM write signals of the matrix store manager
interface matrix_store_manager_if #(parameter int DATA_W = 32);
   logic              en_input;
   logic              dims_valid;
   logic [2:0]        dim_m;
   logic [2:0]        dim_n;
   logic              rx_done;
   logic [7:0]        base_addr;
   logic              addr_ready;
   logic [2:0]        alloc_slot;
   logic              alloc_overwrite;
   logic              in_we;
   logic [7:0]        in_addr;
   logic [DATA_W-1:0] in_data;
   logic              res_we;
   logic [7:0]        res_addr;
   logic [DATA_W-1:0] res_data;
   logic              res_ready;
   logic              mem_we;
   logic [7:0]        mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              qry_valid;
   logic [2:0]        qry_slot;
   logic              qry_hit;
   logic [2:0]        qry_m;
   logic [2:0]        qry_n;
   logic [7:0]        qry_base;
   logic [7:0]        slot_valid_mask;
   logic              clr_all;
   modport slave (
      input  en_input, dims_valid, dim_m, dim_n, rx_done, in_we, in_addr, in_data,
             res_we, res_addr, res_data, qry_valid, qry_slot, clr_all,
      output base_addr, addr_ready, alloc_slot, alloc_overwrite, res_ready,
             mem_we, mem_addr, mem_data, qry_hit, qry_m, qry_n, qry_base, slot_valid_mask
   );
   modport master (
      output en_input, dims_valid, dim_m, dim_n, rx_done, in_we, in_addr, in_data,
             res_we, res_addr, res_data, qry_valid, qry_slot, clr_all,
      input  base_addr, addr_ready, alloc_slot, alloc_overwrite, res_ready,
             mem_we, mem_addr, mem_data, qry_hit, qry_m, qry_n, qry_base, slot_valid_mask
   );
endinterface

// File: rtl/matrix_store_manager.sv
// matrix_store_manager: slot allocator, metadata table and BRAM write arbiter for the matrix store
module matrix_store_manager #(
   parameter int NUM_SLOTS   = 8,
   parameter int SLOT_WORDS  = 32,
   parameter int MAX_PER_DIM = 2,
   parameter int DATA_W      = 32
) (
   input logic                  clk,
   input logic                  rst_n,
   matrix_store_manager_if.slave bus_if
);
   localparam int SW = $clog2(NUM_SLOTS);
   localparam int OW = $clog2(SLOT_WORDS);
   typedef logic [SW-1:0] slot_t;
   typedef enum logic [1:0] {IDLE, SCAN, GRANT, FILL} state_e;
   state_e                        state_q, state_d;
   logic [2:0]                    m_q, m_d, n_q, n_d;
   slot_t                         victim_q, victim_d;
   logic                          ovw_q, ovw_d, dv_q, commit, clr_vic;
   logic [NUM_SLOTS-1:0]          valid_q, valid_d;
   logic [NUM_SLOTS-1:0][2:0]     tm_q, tm_d, tn_q, tn_d, age_q, age_d;
   int                            cnt;
   logic                          same_found, free_found, vic_ovw;
   slot_t                         same_idx, free_idx, old_idx, vic;
   logic [2:0]                    same_age, old_age;
   logic                          mem_we_q, qry_hit_q;
   logic [7:0]                    mem_addr_q, qry_base_q;
   logic [DATA_W-1:0]             mem_data_q;
   logic [2:0]                    qry_m_q, qry_n_q;
   // victim choice: full same-dim group first, then lowest free slot, then oldest overall
   always_comb begin
      cnt = 0;
      same_found = 1'b0;
      same_idx = '0;
      same_age = '0;
      free_found = 1'b0;
      free_idx = '0;
      old_idx = '0;
      old_age = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx = slot_t'(i);
         end
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (valid_q[i] && tm_q[i] == m_q && tn_q[i] == n_q) begin
            cnt++;
            if (!same_found || age_q[i] > same_age) begin
               same_found = 1'b1;
               same_idx = slot_t'(i);
               same_age = age_q[i];
            end
         end
         if (age_q[i] > old_age) begin
            old_idx = slot_t'(i);
            old_age = age_q[i];
         end
      end
      vic = (cnt >= MAX_PER_DIM) ? same_idx : free_found ? free_idx : old_idx;
      vic_ovw = (cnt >= MAX_PER_DIM) || !free_found;
   end
   // allocation FSM next state; the pending slot is victim_q with dims m_q/n_q
   always_comb begin
      state_d = state_q;
      m_d = m_q;
      n_d = n_q;
      victim_d = victim_q;
      ovw_d = ovw_q;
      commit = 1'b0;
      clr_vic = 1'b0;
      case (state_q)
         IDLE:
            if (bus_if.dims_valid && bus_if.en_input) begin
               m_d = bus_if.dim_m;
               n_d = bus_if.dim_n;
               state_d = SCAN;
            end
         SCAN: begin
            victim_d = bus_if.en_input ? vic : victim_q;
            ovw_d = bus_if.en_input ? vic_ovw : ovw_q;
            state_d = bus_if.en_input ? GRANT : IDLE;
         end
         GRANT: begin
            clr_vic = 1'b1;
            state_d = bus_if.en_input ? FILL : IDLE;
         end
         default:
            if (!bus_if.en_input) state_d = IDLE;
            else if (bus_if.dims_valid && !dv_q) begin
               commit = 1'b1;
               m_d = bus_if.dim_m;
               n_d = bus_if.dim_n;
               state_d = SCAN;
            end else if (bus_if.rx_done) begin
               commit = 1'b1;
               state_d = IDLE;
            end
      endcase
      if (bus_if.clr_all) state_d = IDLE;
   end
   // metadata table next state; clr_all overrides a same-cycle commit
   always_comb begin
      valid_d = valid_q;
      tm_d = tm_q;
      tn_d = tn_q;
      age_d = age_q;
      if (clr_vic) valid_d[victim_q] = 1'b0;
      if (commit) begin
         for (int i = 0; i < NUM_SLOTS; i++)
            if (valid_q[i]) age_d[i] = (&age_q[i]) ? age_q[i] : age_q[i] + 3'd1;
         valid_d[victim_q] = 1'b1;
         tm_d[victim_q] = m_q;
         tn_d[victim_q] = n_q;
         age_d[victim_q] = '0;
      end
      if (bus_if.clr_all) begin
         valid_d = '0;
         age_d = '0;
      end
   end
   // FSM and table registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q <= '0;
         n_q <= '0;
         victim_q <= '0;
         ovw_q <= 1'b0;
         dv_q <= 1'b0;
         valid_q <= '0;
         tm_q <= '0;
         tn_q <= '0;
         age_q <= '0;
      end else begin
         state_q <= state_d;
         m_q <= m_d;
         n_q <= n_d;
         victim_q <= victim_d;
         ovw_q <= ovw_d;
         dv_q <= bus_if.dims_valid;
         valid_q <= valid_d;
         tm_q <= tm_d;
         tn_q <= tn_d;
         age_q <= age_d;
      end
   end
   // registered write port and lookup results; input writes always win
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we_q <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         qry_hit_q <= 1'b0;
         qry_m_q <= '0;
         qry_n_q <= '0;
         qry_base_q <= '0;
      end else begin
         mem_we_q <= bus_if.in_we || bus_if.res_we;
         mem_addr_q <= bus_if.in_we ? bus_if.in_addr : bus_if.res_addr;
         mem_data_q <= bus_if.in_we ? bus_if.in_data : bus_if.res_data;
         if (bus_if.qry_valid) begin
            qry_hit_q <= valid_q[bus_if.qry_slot];
            qry_m_q <= tm_q[bus_if.qry_slot];
            qry_n_q <= tn_q[bus_if.qry_slot];
            qry_base_q <= {bus_if.qry_slot, {OW{1'b0}}};
         end
      end
   end
   assign bus_if.addr_ready = state_q == GRANT;
   assign bus_if.base_addr = {victim_q, {OW{1'b0}}};
   assign bus_if.alloc_slot = victim_q;
   assign bus_if.alloc_overwrite = ovw_q;
   assign bus_if.res_ready = bus_if.res_we && !bus_if.in_we;
   assign bus_if.mem_we = mem_we_q;
   assign bus_if.mem_addr = mem_addr_q;
   assign bus_if.mem_data = mem_data_q;
   assign bus_if.qry_hit = qry_hit_q;
   assign bus_if.qry_m = qry_m_q;
   assign bus_if.qry_n = qry_n_q;
   assign bus_if.qry_base = qry_base_q;
   assign bus_if.slot_valid_mask = valid_q;
endmodule

// File: tb/tb_matrix_store_manager.sv
// tb_matrix_store_manager: directed scoreboard bench for the matrix store manager
module tb_matrix_store_manager;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   matrix_store_manager_if ifc();
   matrix_store_manager dut (.clk(clk), .rst_n(rst_n), .bus_if(ifc));
   typedef struct {int slot; logic ovw;} grant_t;
   grant_t exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic idle_inputs();
      ifc.en_input = 1'b1;
      ifc.dims_valid = 1'b0;
      ifc.dim_m = '0;
      ifc.dim_n = '0;
      ifc.rx_done = 1'b0;
      ifc.in_we = 1'b0;
      ifc.in_addr = '0;
      ifc.in_data = '0;
      ifc.res_we = 1'b0;
      ifc.res_addr = '0;
      ifc.res_data = '0;
      ifc.qry_valid = 1'b0;
      ifc.qry_slot = '0;
      ifc.clr_all = 1'b0;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic request(input int m, input int n, input int slot, input logic ovw);
      grant_t e;
      int lat;
      exp_q.push_back('{slot, ovw});
      @(negedge clk);
      ifc.en_input = 1'b1;
      ifc.dim_m = 3'(m);
      ifc.dim_n = 3'(n);
      ifc.dims_valid = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ifc.addr_ready && lat < 10);
      ifc.dims_valid = 1'b0;
      e = exp_q.pop_front();
      chk("grant_latency", 32'(lat), 2);
      chk("grant_base", 32'(ifc.base_addr), 32'(e.slot * 32));
      chk("grant_slot", 32'(ifc.alloc_slot), 32'(e.slot));
      chk("grant_ovw", 32'(ifc.alloc_overwrite), 32'(e.ovw));
   endtask
   task automatic commit();
      @(negedge clk);
      ifc.rx_done = 1'b1;
      @(negedge clk);
      ifc.rx_done = 1'b0;
   endtask
   task automatic query(input int slot, input logic hit, input int m, input int n);
      @(negedge clk);
      ifc.qry_valid = 1'b1;
      ifc.qry_slot = 3'(slot);
      @(negedge clk);
      ifc.qry_valid = 1'b0;
      chk("qry_hit", 32'(ifc.qry_hit), 32'(hit));
      chk("qry_base", 32'(ifc.qry_base), 32'(slot * 32));
      if (hit) begin
         chk("qry_m", 32'(ifc.qry_m), 32'(m));
         chk("qry_n", 32'(ifc.qry_n), 32'(n));
      end
   endtask
   initial begin
      int dm[8] = '{1, 1, 1, 1, 1, 2, 2, 2};
      int dn[8] = '{1, 2, 3, 4, 5, 1, 2, 3};
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("rst_addr_ready", 32'(ifc.addr_ready), 0);
      chk("rst_base_addr", 32'(ifc.base_addr), 0);
      chk("rst_alloc_slot", 32'(ifc.alloc_slot), 0);
      chk("rst_mem_we", 32'(ifc.mem_we), 0);
      chk("rst_qry_hit", 32'(ifc.qry_hit), 0);
      chk("rst_mask", 32'(ifc.slot_valid_mask), 0);
      rst_n = 1'b1;
      request(2, 3, 0, 1'b0);
      commit();
      chk("single_mask", 32'(ifc.slot_valid_mask), 32'h01);
      query(0, 1'b1, 2, 3);
      do_reset();
      request(2, 2, 0, 1'b0);
      commit();
      request(2, 2, 1, 1'b0);
      commit();
      request(2, 2, 0, 1'b1);
      query(0, 1'b0, 0, 0);
      commit();
      chk("samedim_mask", 32'(ifc.slot_valid_mask), 32'h03);
      query(0, 1'b1, 2, 2);
      do_reset();
      request(3, 3, 0, 1'b0);
      request(3, 3, 1, 1'b0);
      chk("gen_pending_mask", 32'(ifc.slot_valid_mask), 32'h01);
      commit();
      chk("gen_mask", 32'(ifc.slot_valid_mask), 32'h03);
      @(negedge clk);
      ifc.in_we = 1'b1;
      ifc.in_addr = 8'h05;
      ifc.in_data = 32'hAAAA_0005;
      ifc.res_we = 1'b1;
      ifc.res_addr = 8'h40;
      ifc.res_data = 32'hBBBB_0040;
      #1 chk("arb_res_blocked", 32'(ifc.res_ready), 0);
      @(negedge clk);
      chk("arb_in_we", 32'(ifc.mem_we), 1);
      chk("arb_in_addr", 32'(ifc.mem_addr), 32'h05);
      chk("arb_in_data", ifc.mem_data, 32'hAAAA_0005);
      ifc.in_we = 1'b0;
      #1 chk("arb_res_ready", 32'(ifc.res_ready), 1);
      @(negedge clk);
      chk("arb_res_addr", 32'(ifc.mem_addr), 32'h40);
      chk("arb_res_data", ifc.mem_data, 32'hBBBB_0040);
      ifc.res_we = 1'b0;
      @(negedge clk);
      chk("arb_idle_we", 32'(ifc.mem_we), 0);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         request(dm[i], dn[i], i, 1'b0);
         commit();
      end
      chk("full_mask", 32'(ifc.slot_valid_mask), 32'hFF);
      request(4, 5, 0, 1'b1);
      commit();
      query(0, 1'b1, 4, 5);
      request(5, 5, 1, 1'b1);
      commit();
      request(5, 4, 2, 1'b1);
      @(negedge clk);
      ifc.en_input = 1'b0;
      @(negedge clk);
      chk("abort_mask", 32'(ifc.slot_valid_mask), 32'hFB);
      query(2, 1'b0, 0, 0);
      request(5, 4, 2, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mask", 32'(ifc.slot_valid_mask), 0);
      chk("arst_addr_ready", 32'(ifc.addr_ready), 0);
      chk("arst_base_addr", 32'(ifc.base_addr), 0);
      chk("arst_alloc_slot", 32'(ifc.alloc_slot), 0);
      chk("arst_overwrite", 32'(ifc.alloc_overwrite), 0);
      chk("arst_qry_base", 32'(ifc.qry_base), 0);
      chk("arst_mem_we", 32'(ifc.mem_we), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
